// File: rtl/stack_cmd_driver_if.sv
// Signal bundle between the lab host, the stack command driver and the stack:
// host load/report signals plus the stack's OP/IN and OUT/OUT_VALID handshake.
interface stack_cmd_driver_if;
  logic       LOAD_VALID;
  logic       LOAD_OP;
  logic [3:0] LOAD_DATA;
  logic       LOAD_READY;
  logic       START;
  logic       BUSY;
  logic       IN_VALID;
  logic       OP;
  logic [3:0] IN;
  logic [5:0] OUT;
  logic       OUT_VALID;
  logic       DONE;
  logic [5:0] RESULT;
  logic [5:0] EXPECT;
  logic       MATCH;
  logic       TIMEOUT_ERR;

  modport master (
    input  LOAD_VALID, LOAD_OP, LOAD_DATA, START, OUT, OUT_VALID,
    output LOAD_READY, BUSY, IN_VALID, OP, IN, DONE, RESULT, EXPECT, MATCH, TIMEOUT_ERR
  );

  modport slave (
    output LOAD_VALID, LOAD_OP, LOAD_DATA, START, OUT, OUT_VALID,
    input  LOAD_READY, BUSY, IN_VALID, OP, IN, DONE, RESULT, EXPECT, MATCH, TIMEOUT_ERR
  );
endinterface

// File: rtl/stack_cmd_driver.sv
// Buffers host push/pop commands, replays them as one burst to the 4-deep summing
// stack, and compares the stack's result against an internal model of the stack.
module stack_cmd_driver #(
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 15
) (
  input logic                CLK,
  input logic                RESET,
  stack_cmd_driver_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TW = $clog2(TIMEOUT + 2);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_REPORT} state_t;
  state_t state, next_state;

  logic [4:0]    queue_mem [DEPTH];
  logic [CW-1:0] count;
  logic [CW-1:0] send_idx;
  logic [TW-1:0] wait_cnt;
  logic [3:0]    model_ent [4];
  logic [2:0]    model_depth;
  logic          in_valid;
  logic          op;
  logic [3:0]    in_data;
  logic          done;
  logic [5:0]    result;
  logic [5:0]    expect_sum;
  logic          match;
  logic          timeout_err;
  logic [5:0]    model_sum;
  logic [4:0]    send_entry;
  logic          load_ready;
  logic          load_fire;
  logic          start_fire;
  logic          send_last;
  logic          wait_expired;

  assign load_ready   = (state == S_IDLE) && (count < CW'(DEPTH)) && !RESET;
  assign load_fire    = bus.LOAD_VALID && load_ready;
  assign start_fire   = (state == S_IDLE) && bus.START && (count != '0);
  assign send_last    = (send_idx == count);
  assign send_entry   = queue_mem[send_idx[AW-1:0]];
  assign wait_expired = (wait_cnt == TW'(TIMEOUT));
  assign model_sum    = 6'(model_ent[0]) + 6'(model_ent[1]) + 6'(model_ent[2]) + 6'(model_ent[3]);

  assign bus.LOAD_READY  = load_ready;
  assign bus.BUSY        = (state != S_IDLE);
  assign bus.IN_VALID    = in_valid;
  assign bus.OP          = op;
  assign bus.IN          = in_data;
  assign bus.DONE        = done;
  assign bus.RESULT      = result;
  assign bus.EXPECT      = expect_sum;
  assign bus.MATCH       = match;
  assign bus.TIMEOUT_ERR = timeout_err;

  // Queue storage needs no reset: count alone decides which entries are live.
  always_ff @(posedge CLK) begin
    if (load_fire) queue_mem[count[AW-1:0]] <= {bus.LOAD_OP, bus.LOAD_DATA};
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (start_fire) next_state = S_SEND;
      S_SEND:   if (send_last) next_state = S_WAIT;
      S_WAIT:   if (bus.OUT_VALID || wait_expired) next_state = S_REPORT;
      S_REPORT: next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count       <= '0;
      send_idx    <= '0;
      wait_cnt    <= '0;
      in_valid    <= 1'b0;
      op          <= 1'b0;
      in_data     <= '0;
      done        <= 1'b0;
      result      <= '0;
      expect_sum  <= '0;
      match       <= 1'b0;
      timeout_err <= 1'b0;
      model_depth <= '0;
      for (int i = 0; i < 4; i++) model_ent[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_fire) count <= count + 1'b1;
          if (start_fire) begin
            send_idx    <= '0;
            result      <= '0;
            expect_sum  <= '0;
            match       <= 1'b0;
            timeout_err <= 1'b0;
            model_depth <= '0;
            for (int i = 0; i < 4; i++) model_ent[i] <= '0;
          end
        end
        S_SEND: begin
          if (!send_last) begin
            in_valid <= 1'b1;
            op       <= send_entry[4];
            in_data  <= send_entry[3:0];
            send_idx <= send_idx + 1'b1;
            // The model tracks what the stack should hold, including its overflow/underflow drops.
            if (send_entry[4]) begin
              if (model_depth < 3'd4) begin
                model_ent[model_depth[1:0]] <= send_entry[3:0];
                model_depth                 <= model_depth + 3'd1;
              end
            end else if (model_depth != 3'd0) begin
              model_ent[model_depth[1:0] - 2'd1] <= '0;
              model_depth                        <= model_depth - 3'd1;
            end
          end else begin
            in_valid <= 1'b0;
            op       <= 1'b0;
            in_data  <= '0;
            wait_cnt <= '0;
          end
        end
        S_WAIT: begin
          if (bus.OUT_VALID) begin
            done        <= 1'b1;
            result      <= bus.OUT;
            expect_sum  <= model_sum;
            match       <= (bus.OUT == model_sum) && (model_depth != 3'd0);
            timeout_err <= 1'b0;
          end else if (wait_expired) begin
            done        <= 1'b1;
            result      <= '0;
            expect_sum  <= model_sum;
            match       <= (model_depth == 3'd0);
            timeout_err <= (model_depth != 3'd0);
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        S_REPORT: count <= '0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_stack_cmd_driver.sv
// Scoreboard bench for stack_cmd_driver: a behavioural stack answers each burst and a
// monitor checks every beat and every DONE report against a queue-based stack model.
module tb_stack_cmd_driver;
  localparam int DEPTH     = 8;
  localparam int TIMEOUT   = 15;
  localparam int RESP_OK   = 0;
  localparam int RESP_VAL  = 1;
  localparam int RESP_NONE = 2;

  typedef struct {
    int result;
    int expSum;
    int match;
    int terr;
    int doneCyc;
  } exp_t;

  logic CLK = 1'b0;
  logic RESET;

  stack_cmd_driver_if bus();

  stack_cmd_driver #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK),
    .RESET(RESET),
    .bus(bus.master)
  );

  always #5 CLK = ~CLK;

  int compared = 0;
  int failed = 0;
  int cyc = 0;
  int doneCount = 0;
  exp_t expQ[$];
  logic [4:0] expBeats[$];
  int respMode = RESP_OK;
  logic [5:0] respValue = '0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Stack behaviour from first principles: bounded push, guarded pop, sum of what remains.
  function automatic void refModel(input logic [4:0] cmds[$], output int sum, output int depth);
    int st[$];
    sum = 0;
    foreach (cmds[i]) begin
      if (cmds[i][4]) begin
        if (st.size() < 4) st.push_back(int'(cmds[i][3:0]));
      end else if (st.size() > 0) begin
        void'(st.pop_back());
      end
    end
    foreach (st[i]) sum += st[i];
    depth = st.size();
  endfunction

  task automatic checkOutput(input string name, input int actual, input int required);
    compared++;
    if (actual !== required) begin
      failed++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  initial begin
    logic prevIv;
    logic [4:0] seen[$];
    int s, d;
    prevIv = 1'b0;
    bus.OUT_VALID = 1'b0;
    bus.OUT = '0;
    forever begin
      @(posedge CLK);
      #1;
      bus.OUT_VALID = 1'b0;
      bus.OUT = '0;
      if (bus.IN_VALID === 1'b1) begin
        if (!prevIv) seen.delete();
        seen.push_back({bus.OP, bus.IN});
      end else if (prevIv && respMode != RESP_NONE) begin
        refModel(seen, s, d);
        bus.OUT_VALID = 1'b1;
        bus.OUT = (respMode == RESP_OK) ? 6'(s) : respValue;
      end
      prevIv = bus.IN_VALID;
    end
  end

  initial begin
    exp_t x;
    logic [4:0] eb;
    forever begin
      @(posedge CLK);
      #1;
      if (bus.IN_VALID === 1'b1) begin
        if (expBeats.size() == 0) begin
          compared++;
          failed++;
          $display("[TB] FAIL unexpected_beat: got op=%0d in=%0d, required no beat", bus.OP, bus.IN);
        end else begin
          eb = expBeats.pop_front();
          checkOutput("beat", int'({bus.OP, bus.IN}), int'(eb));
        end
      end
      if (bus.DONE === 1'b1) begin
        doneCount++;
        if (expQ.size() == 0) begin
          compared++;
          failed++;
          $display("[TB] FAIL unexpected_done: got DONE at cycle %0d, required none", cyc);
        end else begin
          x = expQ.pop_front();
          checkOutput("result", bus.RESULT, x.result);
          checkOutput("expect", bus.EXPECT, x.expSum);
          checkOutput("match", bus.MATCH, x.match);
          checkOutput("timeout_err", bus.TIMEOUT_ERR, x.terr);
          checkOutput("done_cycle", cyc, x.doneCyc);
          checkOutput("beats_left", expBeats.size(), 0);
        end
      end
    end
  end

  task automatic applyStimulus(input logic [4:0] cmds[$], input int mode, input logic [5:0] val,
                               input bit sameEdge, input bit spam);
    logic [4:0] acc[$];
    int s, d, t, n, dc0, budget;
    bit started;
    exp_t e;
    started = 1'b0;
    respMode = mode;
    respValue = val;
    foreach (cmds[i]) begin
      @(negedge CLK);
      if (acc.size() == DEPTH) checkOutput("load_ready_full", bus.LOAD_READY, 0);
      else checkOutput("load_ready", bus.LOAD_READY, 1);
      bus.LOAD_VALID = 1'b1;
      bus.LOAD_OP = cmds[i][4];
      bus.LOAD_DATA = cmds[i][3:0];
      if (i == cmds.size() - 1 && sameEdge && acc.size() > 0) begin
        bus.START = 1'b1;
        started = 1'b1;
      end
      if (acc.size() < DEPTH) acc.push_back(cmds[i]);
    end
    if (!started) begin
      @(negedge CLK);
      bus.LOAD_VALID = 1'b0;
      bus.START = 1'b1;
    end
    t = cyc + 1;
    n = acc.size();
    refModel(acc, s, d);
    foreach (acc[i]) expBeats.push_back(acc[i]);
    e.expSum = s;
    if (mode == RESP_OK) begin
      e.result = s; e.match = (d > 0); e.terr = 0; e.doneCyc = t + n + 2;
    end else if (mode == RESP_VAL) begin
      e.result = int'(val); e.match = (int'(val) == s && d > 0); e.terr = 0; e.doneCyc = t + n + 2;
    end else begin
      e.result = 0; e.match = (d == 0); e.terr = (d > 0); e.doneCyc = t + n + TIMEOUT + 2;
    end
    expQ.push_back(e);
    dc0 = doneCount;
    @(negedge CLK);
    bus.START = 1'b0;
    bus.LOAD_VALID = 1'b0;
    checkOutput("busy_after_start", bus.BUSY, 1);
    checkOutput("result_cleared", bus.RESULT, 0);
    checkOutput("expect_cleared", bus.EXPECT, 0);
    checkOutput("match_cleared", bus.MATCH, 0);
    checkOutput("terr_cleared", bus.TIMEOUT_ERR, 0);
    budget = 0;
    while (doneCount == dc0 && budget < 100) begin
      if (spam) begin
        bus.LOAD_VALID = 1'b1;
        bus.LOAD_OP = 1'($urandom);
        bus.LOAD_DATA = 4'($urandom);
      end
      @(negedge CLK);
      budget++;
    end
    bus.LOAD_VALID = 1'b0;
    if (doneCount == dc0) begin
      compared++;
      failed++;
      $display("[TB] FAIL done_timeout: no DONE after %0d cycles, required one", budget);
      expQ.delete();
      expBeats.delete();
    end
  endtask

  task automatic resetMidSend();
    logic [4:0] acc[$];
    acc = '{5'h12, 5'h16, 5'h11};
    respMode = RESP_OK;
    foreach (acc[i]) begin
      @(negedge CLK);
      bus.LOAD_VALID = 1'b1;
      bus.LOAD_OP = acc[i][4];
      bus.LOAD_DATA = acc[i][3:0];
      expBeats.push_back(acc[i]);
    end
    @(negedge CLK);
    bus.LOAD_VALID = 1'b0;
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #1;
    checkOutput("rst_in_valid", bus.IN_VALID, 0);
    checkOutput("rst_busy", bus.BUSY, 0);
    checkOutput("rst_done", bus.DONE, 0);
    @(negedge CLK);
    RESET = 1'b0;
    expBeats.delete();
    #1;
    checkOutput("rst_load_ready", bus.LOAD_READY, 1);
    repeat (TIMEOUT + 10) @(negedge CLK);
    checkOutput("rst_result", bus.RESULT, 0);
    checkOutput("rst_expect", bus.EXPECT, 0);
    checkOutput("rst_match", bus.MATCH, 0);
    checkOutput("rst_terr", bus.TIMEOUT_ERR, 0);
    checkOutput("rst_busy_after", bus.BUSY, 0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [4:0] cmds[$];
    int len;
    bus.LOAD_VALID = 1'b0;
    bus.LOAD_OP = 1'b0;
    bus.LOAD_DATA = '0;
    bus.START = 1'b0;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    checkOutput("reset_in_valid", bus.IN_VALID, 0);
    checkOutput("reset_busy", bus.BUSY, 0);
    checkOutput("reset_done", bus.DONE, 0);
    checkOutput("reset_result", bus.RESULT, 0);
    checkOutput("reset_expect", bus.EXPECT, 0);
    checkOutput("reset_match", bus.MATCH, 0);
    checkOutput("reset_terr", bus.TIMEOUT_ERR, 0);
    checkOutput("reset_load_ready", bus.LOAD_READY, 0);
    RESET = 1'b0;
    #1;
    checkOutput("load_ready_after_reset", bus.LOAD_READY, 1);

    cmds = '{5'h13, 5'h15, 5'h17};
    applyStimulus(cmds, RESP_OK, 6'd0, 1'b0, 1'b0);
    cmds = '{5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F};
    applyStimulus(cmds, RESP_OK, 6'd0, 1'b0, 1'b0);
    applyStimulus(cmds, RESP_VAL, 6'd59, 1'b0, 1'b0);
    cmds = '{5'h14, 5'h00};
    applyStimulus(cmds, RESP_NONE, 6'd0, 1'b0, 1'b0);
    cmds = '{5'h19};
    applyStimulus(cmds, RESP_NONE, 6'd0, 1'b0, 1'b0);

    cmds.delete();
    for (int i = 0; i < DEPTH + 1; i++) cmds.push_back({1'b1, 4'($urandom)});
    applyStimulus(cmds, RESP_OK, 6'd0, 1'b0, 1'b1);

    @(negedge CLK);
    bus.START = 1'b1;
    @(negedge CLK);
    bus.START = 1'b0;
    checkOutput("busy_empty_start", bus.BUSY, 0);
    repeat (3) @(negedge CLK);

    for (int k = 0; k < 25; k++) begin
      cmds.delete();
      len = $urandom_range(1, DEPTH + 1);
      for (int i = 0; i < len; i++) cmds.push_back({1'(($urandom % 4) != 0), 4'($urandom)});
      applyStimulus(cmds, int'($urandom % 3), 6'($urandom), 1'($urandom), 1'($urandom));
    end

    resetMidSend();

    cmds = '{5'h18, 5'h00, 5'h12};
    applyStimulus(cmds, RESP_OK, 6'd0, 1'b1, 1'b0);

    repeat (5) @(negedge CLK);
    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule

// File: doc/stack_cmd_driver.md
# stack_cmd_driver

Command-side master for the 4-deep push/pop summing stack. It buffers a host-loaded list of push/pop commands, replays them as one contiguous IN_VALID burst on the stack's OP/IN interface, then waits for the stack's one-cycle OUT/OUT_VALID result. An internal reference model of the stack computes the expected sum. The block reports the captured result, the expected value, a match flag and a timeout flag. It sits between the lab test host, or a self-check wrapper, and the stack block.

## Interface
Parameters:
- DEPTH, 8: command queue entries; power of two.
- TIMEOUT, 15: WAIT-state cycles allowed for OUT_VALID.

Ports:
- CLK  in  1  clock; all state changes on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- LOAD_VALID  in  1  host command write strobe.
- LOAD_OP  in  1  command opcode: 1 = push, 0 = pop.
- LOAD_DATA  in  4  push data; ignored for pop.
- LOAD_READY  out  1  combinational: state IDLE, queue count < DEPTH, and RESET low.
- START  in  1  begins replay of the queued commands.
- BUSY  out  1  high in SEND, WAIT and REPORT.
- IN_VALID  out  1  to stack: command valid.
- OP  out  1  to stack: opcode.
- IN  out  4  to stack: push data.
- OUT  in  6  from stack: result.
- OUT_VALID  in  1  from stack: result strobe.
- DONE  out  1  one-cycle completion pulse.
- RESULT  out  6  captured OUT; 0 if no response arrived.
- EXPECT  out  6  model sum.
- MATCH  out  1  RESULT agrees with the model.
- TIMEOUT_ERR  out  1  model expected a response and none arrived.

## Operation
- Reset: all registered outputs 0, queue empty (count 0), model cleared (4 entries = 0, depth 0), state IDLE.
- Load: accepted in IDLE when LOAD_VALID && LOAD_READY. The {OP, DATA} pair is appended and count is incremented. Loads outside IDLE or with the queue full are dropped silently.
- START: accepted only in IDLE with pre-edge count > 0; otherwise ignored.
  - A load in the same edge is appended and replayed as the last command.
  - Accepting START clears RESULT, EXPECT, MATCH and TIMEOUT_ERR, and clears the model.
- SEND: one queue entry per cycle drives IN_VALID=1, OP and IN. The model updates from each entry sent:
  - push with depth < 4: write entry[depth] and increment depth.
  - push with depth = 4: ignored.
  - pop with depth > 0: decrement depth and zero the vacated entry.
  - pop with depth = 0: ignored.
- After the last entry, IN_VALID, OP and IN return to 0 and the state moves to WAIT with the wait counter at 0.
- WAIT:
  - OUT_VALID sampled high: RESULT <= OUT, then go to REPORT.
  - Otherwise the counter increments. When it reaches TIMEOUT, go to REPORT with RESULT = 0.
- REPORT: one cycle with DONE=1. Then the queue is emptied (count 0) and the state returns to IDLE.
  - EXPECT = sum of the 4 model entries (zero-extended to 6 bits; maximum 60).
  - MATCH = (response received && RESULT == EXPECT && model depth > 0) || (no response && model depth == 0).
  - TIMEOUT_ERR = no response && model depth > 0.
- RESULT, EXPECT, MATCH and TIMEOUT_ERR hold until the next accepted START or RESET.
- OUT_VALID outside WAIT is ignored.
- Reset mid-operation, any state: at the reset edge IN_VALID, OP, IN and BUSY go to 0, the queue is flushed, and no DONE is issued.

## Timing
- START sampled at edge t with N commands queued:
  - IN_VALID is high in cycles t+1 through t+N.
  - IN_VALID is low from edge t+N+1; WAIT begins at that edge.
- Stack latency: a conforming stack raises OUT_VALID in the cycle after edge t+N+1. The driver captures it at edge t+N+2, and DONE is high in the following cycle.
- No-response case: DONE is high TIMEOUT+1 cycles after WAIT entry.
- BUSY rises at edge t and falls at the edge that ends DONE.
- The earliest next START is accepted in the cycle after DONE.

## Test plan
- Load push 3, push 5, push 7. START → IN_VALID high for 3 cycles with IN = 3, 5, 7. Stack returns 15 → DONE, RESULT=15, EXPECT=15, MATCH=1, TIMEOUT_ERR=0.
- Load 5 pushes of 15 (the 5th is dropped by the model). START → EXPECT=60. Correct stack → MATCH=1. Force OUT=59 → MATCH=0.
- Load push 4, pop. START → model empty. With no OUT_VALID: DONE at TIMEOUT+1 cycles into WAIT, RESULT=0, MATCH=1, TIMEOUT_ERR=0.
- Load push 9 with the stack's OUT_VALID held low → TIMEOUT_ERR=1, MATCH=0, RESULT=0, EXPECT=9.
- Fill the queue with DEPTH loads → LOAD_READY=0 and a 9th load is dropped. LOAD_VALID during SEND is dropped. START with an empty queue → no BUSY.
- Assert RESET in the 2nd SEND cycle → IN_VALID=0 next cycle, no DONE, LOAD_READY=1 after RESET is released, all result outputs 0.
